uart_rx: RTL and testbench

- UART receiver: the neighbouring stage that consumes the serial line produced by uart_tx.
- Oversamples the async serial input with the system clock and recovers 8N1 frames, LSB first.
- Presents each received word on a valid/ready (AXI-Stream style) output, with frame-error and overrun flags.
- Sits at the receive edge of the AXIS-UART bridge, feeding the downstream AXIS consumer/FIFO.

---
 rtl/uart_rx.sv | 209 ++++++++++++++++++++
 tb/tb_uart_rx.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver, 8N1 by default, LSB first.
// The serial line goes through a two-flop synchronizer. A falling edge
// starts a frame. The start bit is re-checked at mid-bit, each data bit is
// sampled one bit period later, and the stop bit is checked at its middle.
// Received words are presented on a valid/ready output. rx_frame_err and
// rx_overrun are one-cycle pulses.
// Optional feature: define UART_RX_PARITY_EN to add an even-parity bit
// between the data bits and the stop bit, plus the rx_parity_err output.
module uart_rx #(
    parameter int clk_rate = 100000000,
    parameter int Baud     = 115200,
    parameter int Word_len = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                Uart_rx,
    output logic [Word_len-1:0] rx_data,
    output logic                rx_data_valid,
    input  logic                rx_data_ready,
    output logic                rx_frame_err,
`ifdef UART_RX_PARITY_EN
    output logic                rx_parity_err,
`endif
    output logic                rx_overrun
);

    localparam int Baud_div = clk_rate / Baud;
    localparam int CW       = $clog2(Baud_div) + 1;
    localparam int BW       = (Word_len > 1) ? $clog2(Word_len) : 1;

    // Terminal counts: half a bit for the start bit, a full bit elsewhere
    localparam logic [CW-1:0] half_lim = CW'(Baud_div / 2 - 1);
    localparam logic [CW-1:0] bit_lim  = CW'(Baud_div - 1);
    localparam logic [BW-1:0] last_bit = BW'(Word_len - 1);

`ifdef UART_RX_PARITY_EN
    localparam int SW = 3;
`else
    localparam int SW = 2;
`endif
    localparam logic [SW-1:0] IDLE   = SW'(0);
    localparam logic [SW-1:0] START  = SW'(1);
    localparam logic [SW-1:0] DATA   = SW'(2);
    localparam logic [SW-1:0] STOP   = SW'(3);
`ifdef UART_RX_PARITY_EN
    localparam logic [SW-1:0] PARITY = SW'(4);
`endif

    logic                sync1;
    logic                rx_s;
    logic                rx_s_d;
    logic [SW-1:0]       state;
    logic [CW-1:0]       baud_cnt;
    logic [BW-1:0]       bit_cnt;
    logic [Word_len-1:0] shift_reg;
`ifdef UART_RX_PARITY_EN
    logic                par_bit;
`endif

    logic fall_edge;
    logic start_tc;
    logic bit_tc;
    logic stop_done;
    logic out_free;
    logic parity_bad;

    // Event decode for the FSM and the output stage
    always_comb begin
        fall_edge = rx_s_d & ~rx_s;
        start_tc  = (baud_cnt == half_lim);
        bit_tc    = (baud_cnt == bit_lim);
        stop_done = (state == STOP) && bit_tc;
        // A load is allowed when the slot is empty or is being consumed this cycle
        out_free  = ~rx_data_valid | rx_data_ready;
`ifdef UART_RX_PARITY_EN
        parity_bad = ^{shift_reg, par_bit};
`else
        parity_bad = 1'b0;
`endif
    end

    // Two-flop synchronizer plus a delayed copy for falling-edge detection
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1  <= 1'b1;
            rx_s   <= 1'b1;
            rx_s_d <= 1'b1;
        end else begin
            sync1  <= Uart_rx;
            rx_s   <= sync1;
            rx_s_d <= rx_s;
        end
    end

    // Frame FSM: bit timing, data shifting and state sequencing
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            baud_cnt  <= {CW{1'b0}};
            bit_cnt   <= {BW{1'b0}};
            shift_reg <= {Word_len{1'b0}};
`ifdef UART_RX_PARITY_EN
            par_bit   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    baud_cnt <= {CW{1'b0}};
                    bit_cnt  <= {BW{1'b0}};
                    if (fall_edge) begin
                        state <= START;
                    end
                end
                START: begin
                    if (start_tc) begin
                        baud_cnt <= {CW{1'b0}};
                        // Line back high at mid start bit: treat it as a glitch
                        state    <= rx_s ? IDLE : DATA;
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (bit_tc) begin
                        baud_cnt  <= {CW{1'b0}};
                        shift_reg <= {rx_s, shift_reg[Word_len-1:1]};
                        if (bit_cnt == last_bit) begin
                            bit_cnt <= {BW{1'b0}};
`ifdef UART_RX_PARITY_EN
                            state   <= PARITY;
`else
                            state   <= STOP;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + BW'(1);
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (bit_tc) begin
                        baud_cnt <= {CW{1'b0}};
                        par_bit  <= rx_s;
                        state    <= STOP;
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
`endif
                STOP: begin
                    if (bit_tc) begin
                        // Leave at mid stop bit so the next start edge is not missed
                        baud_cnt <= {CW{1'b0}};
                        state    <= IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    baud_cnt <= {CW{1'b0}};
                    bit_cnt  <= {BW{1'b0}};
                end
            endcase
        end
    end

    // Output register, handshake and one-cycle error pulses
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_data       <= {Word_len{1'b0}};
            rx_data_valid <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            rx_parity_err <= 1'b0;
`endif
        end else begin
            rx_frame_err <= 1'b0;
            rx_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            rx_parity_err <= 1'b0;
`endif
            if (rx_data_valid && rx_data_ready) begin
                rx_data_valid <= 1'b0;
            end else begin
                rx_data_valid <= rx_data_valid;
            end
            if (stop_done) begin
                if (!rx_s) begin
                    rx_frame_err <= 1'b1;
                end else if (parity_bad) begin
`ifdef UART_RX_PARITY_EN
                    rx_parity_err <= 1'b1;
`endif
                end else if (out_free) begin
                    // This load overrides the clear when both happen together
                    rx_data       <= shift_reg;
                    rx_data_valid <= 1'b1;
                end else begin
                    rx_overrun <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed, table-driven bench for uart_rx (Baud_div = 10).
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       line;
    logic       ready;
    logic [7:0] rx_data;
    logic       valid;
    logic       ferr;
    logic       ovr;
`ifdef UART_RX_PARITY_EN
    logic       perr;
    localparam int LAT = 108;
`else
    localparam int LAT = 98;
`endif

    always #5 clk = ~clk;

    uart_rx #(.clk_rate(1000000), .Baud(100000), .Word_len(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .Uart_rx       (line),
        .rx_data       (rx_data),
        .rx_data_valid (valid),
        .rx_data_ready (ready),
        .rx_frame_err  (ferr),
`ifdef UART_RX_PARITY_EN
        .rx_parity_err (perr),
`endif
        .rx_overrun    (ovr)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Cycle counter used for latency measurement
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: counts pulses and cycles, captures consumed words (mid-cycle)
    int         valid_cnt = 0, ferr_cnt = 0, ovr_cnt = 0, both_cnt = 0;
    int         rise_cnt = 0, fall_cnt = 0, rise_cyc = 0, cap_cnt = 0, perr_cnt = 0;
    logic       prev_valid = 1'b0;
    logic [7:0] cap_mem [0:63];
    always @(negedge clk) begin
        if (valid) valid_cnt <= valid_cnt + 1;
        if (ferr) ferr_cnt <= ferr_cnt + 1;
        if (ovr) ovr_cnt <= ovr_cnt + 1;
        if (ferr && ovr) both_cnt <= both_cnt + 1;
`ifdef UART_RX_PARITY_EN
        if (perr) perr_cnt <= perr_cnt + 1;
`endif
        if (valid && !prev_valid) begin
            rise_cnt <= rise_cnt + 1;
            rise_cyc <= cyc;
        end
        if (!valid && prev_valid) fall_cnt <= fall_cnt + 1;
        prev_valid <= valid;
        if (valid && ready && cap_cnt < 64) begin
            cap_mem[cap_cnt] <= rx_data;
            cap_cnt <= cap_cnt + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance to 2 time units after the next rising edge
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        line = 1'b0;
        repeat (10) tick();
        for (int i = 0; i < 8; i++) begin
            line = d[i];
            repeat (10) tick();
        end
`ifdef UART_RX_PARITY_EN
        line = ^d;
        repeat (10) tick();
`endif
        line = stop;
        repeat (10) tick();
        line = 1'b1;
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       exp_word;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs [6];
    int   s_valid, s_ferr, s_ovr, s_cap, s_rise, s_fall, c0;

    initial begin
        #1000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{8'h00, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{8'hFF, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{8'h55, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{8'h0F, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{8'hC3, 1'b1, 1'b1, 1'b0};

        rst = 1'b0; line = 1'b1; ready = 1'b0;
        repeat (3) tick();
        check("reset_data", 32'(rx_data), 32'h0);
        check("reset_valid", 32'(valid), 32'h0);
        check("reset_ferr", 32'(ferr), 32'h0);
        check("reset_ovr", 32'(ovr), 32'h0);
        rst = 1'b1;
        repeat (5) tick();

        // Table: single frames with ready held high
        ready = 1'b1;
        for (int v = 0; v < 6; v++) begin
            s_valid = valid_cnt; s_ferr = ferr_cnt; s_ovr = ovr_cnt; s_cap = cap_cnt;
            c0 = cyc;
            send_frame(vecs[v].data, vecs[v].stop);
            repeat (5) tick();
            check($sformatf("vec%0d_valid_cycles", v), 32'(valid_cnt - s_valid), 32'(vecs[v].exp_word));
            check($sformatf("vec%0d_frame_err", v), 32'(ferr_cnt - s_ferr), 32'(vecs[v].exp_ferr));
            check($sformatf("vec%0d_overrun", v), 32'(ovr_cnt - s_ovr), 32'h0);
            if (vecs[v].exp_word) begin
                check($sformatf("vec%0d_data", v), 32'(cap_mem[s_cap]), 32'(vecs[v].data));
                check($sformatf("vec%0d_latency", v), 32'(rise_cyc - c0), 32'(LAT));
            end else begin
                check($sformatf("vec%0d_no_word", v), 32'(cap_cnt - s_cap), 32'h0);
            end
        end

        // Glitch: 3 low cycles, then a good frame
        s_valid = valid_cnt; s_ferr = ferr_cnt; s_ovr = ovr_cnt; s_cap = cap_cnt;
        line = 1'b0;
        repeat (3) tick();
        line = 1'b1;
        repeat (20) tick();
        check("glitch_valid", 32'(valid_cnt - s_valid), 32'h0);
        check("glitch_flags", 32'((ferr_cnt - s_ferr) + (ovr_cnt - s_ovr)), 32'h0);
        send_frame(8'h3C, 1'b1);
        repeat (5) tick();
        check("glitch_next_count", 32'(cap_cnt - s_cap), 32'h1);
        check("glitch_next_data", 32'(cap_mem[s_cap]), 32'h3C);

        // Overrun: three back-to-back frames with ready low
        ready = 1'b0;
        s_ovr = ovr_cnt; s_ferr = ferr_cnt; s_cap = cap_cnt;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        send_frame(8'h33, 1'b1);
        repeat (5) tick();
        check("ovr_pulses", 32'(ovr_cnt - s_ovr), 32'h2);
        check("ovr_ferr", 32'(ferr_cnt - s_ferr), 32'h0);
        check("ovr_held_valid", 32'(valid), 32'h1);
        check("ovr_held_data", 32'(rx_data), 32'h11);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        check("ovr_consume_valid", 32'(valid), 32'h0);
        check("ovr_consume_data", 32'(cap_mem[s_cap]), 32'h11);
        repeat (3) tick();

        // Simultaneous consume and load
        s_ovr = ovr_cnt; s_cap = cap_cnt;
        send_frame(8'h12, 1'b1);
        s_fall = fall_cnt;
        fork
            send_frame(8'h34, 1'b1);
            begin
                repeat (LAT - 1) tick();
                ready = 1'b1;
                tick();
                ready = 1'b0;
            end
        join
        check("simul_valid", 32'(valid), 32'h1);
        check("simul_data", 32'(rx_data), 32'h34);
        check("simul_no_bubble", 32'(fall_cnt - s_fall), 32'h0);
        check("simul_overrun", 32'(ovr_cnt - s_ovr), 32'h0);
        check("simul_consumed", 32'(cap_mem[s_cap]), 32'h12);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        check("simul_drain", 32'(valid), 32'h0);
        repeat (3) tick();

        // Reset in the middle of a frame, with a word held on the output
        send_frame(8'h5A, 1'b1);
        repeat (3) tick();
        s_rise = rise_cnt; s_ferr = ferr_cnt; s_ovr = ovr_cnt;
        fork
            send_frame(8'hFF, 1'b1);
            begin
                repeat (40) tick();
                rst = 1'b0;
                tick();
                check("midrst_valid", 32'(valid), 32'h0);
                check("midrst_data", 32'(rx_data), 32'h0);
                rst = 1'b1;
            end
        join
        repeat (5) tick();
        check("midrst_no_word", 32'(rise_cnt - s_rise), 32'h0);
        check("midrst_no_flags", 32'((ferr_cnt - s_ferr) + (ovr_cnt - s_ovr)), 32'h0);
        ready = 1'b1;
        s_cap = cap_cnt;
        send_frame(8'h81, 1'b1);
        repeat (5) tick();
        check("midrst_next_count", 32'(cap_cnt - s_cap), 32'h1);
        check("midrst_next_data", 32'(cap_mem[s_cap]), 32'h81);

        check("flags_exclusive", 32'(both_cnt), 32'h0);
        check("no_parity_err", 32'(perr_cnt), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
